// File: rtl/bcd_display_scan.sv
// -----------------------------------------------------------------------------
// bcd_display_scan
//
// Multiplexed seven-segment driver. It sits directly after the binary-to-BCD
// converter.
//
// A load strobe captures the packed BCD word into a shadow register. The shadow
// is copied into the active register only at a scan-frame boundary, so no frame
// ever mixes old and new digits.
//
// The active digits are time-multiplexed onto a shared active-low segment bus,
// with one active-low anode enable per digit. Two display options:
//   - optional leading-zero blanking
//   - a dash for nibbles that are not decimal digits
//
// Parameters
//   DIGITS       number of BCD digits / anodes (4*DIGITS is the BCD word width)
//   REFRESH_DIV  clock cycles each digit stays lit (>= 2)
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-low
//   bcd_in       packed BCD, nibble k = bcd_in[4k+3:4k], digit 0 least significant
//   load         capture strobe for bcd_in (single-cycle or held)
//   blank_lz     1 = blank leading zeros (sampled every cycle)
//   seg          segments {g,f,e,d,c,b,a}, active-low, registered
//   an           anode enables, active-low, one-hot-low or all-high, registered
//   frame_start  one-cycle pulse when active is reloaded at a frame boundary
// -----------------------------------------------------------------------------
module bcd_display_scan #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_start
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    logic [4*DIGITS-1:0] shadow;
    logic [4*DIGITS-1:0] active;
    logic                pending;
    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;

    logic                tick;
    logic                wrap;
    logic [6:0]          seg_next;
    logic [DIGITS-1:0]   an_next;

    assign tick = (cnt == CNT_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    // Refresh timer and digit index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shadow capture and frame-synchronous transfer into active.
    // A load landing in the wrap cycle is applied to that same boundary, so
    // pending ends at 0 rather than being re-armed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow      <= '0;
            active      <= '0;
            pending     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (load) begin
                shadow <= bcd_in;
            end
            if (wrap && (pending || load)) begin
                active      <= load ? bcd_in : shadow;
                pending     <= 1'b0;
                frame_start <= 1'b1;
            end else begin
                frame_start <= 1'b0;
                if (load) begin
                    pending <= 1'b1;
                end
            end
        end
    end

    // Digit decode from the current index and active word.
    always_comb begin
        logic [3:0] nib;
        logic       zero_above;

        nib        = 4'd0;
        zero_above = 1'b1;
        seg_next   = SEG_OFF;
        an_next    = '1;

        for (int k = 0; k < DIGITS; k++) begin
            if (IDX_W'(k) == idx) begin
                nib = active[4*k +: 4];
            end
            // Leading-zero test: every nibble at or above idx must be zero.
            if ((IDX_W'(k) >= idx) && (active[4*k +: 4] != 4'd0)) begin
                zero_above = 1'b0;
            end
        end

        case (nib)
            4'd0:    seg_next = 7'h40;
            4'd1:    seg_next = 7'h79;
            4'd2:    seg_next = 7'h24;
            4'd3:    seg_next = 7'h30;
            4'd4:    seg_next = 7'h19;
            4'd5:    seg_next = 7'h12;
            4'd6:    seg_next = 7'h02;
            4'd7:    seg_next = 7'h78;
            4'd8:    seg_next = 7'h00;
            4'd9:    seg_next = 7'h10;
            default: seg_next = SEG_DASH;
        endcase

        // Digit 0 is never blanked, so a zero value still shows "0".
        if (blank_lz && (idx != '0) && zero_above) begin
            seg_next = SEG_OFF;
            an_next  = '1;
        end else begin
            an_next[idx] = 1'b0;
        end
    end

    // Registered outputs: one cycle behind idx/active.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg <= SEG_OFF;
            an  <= '1;
        end else begin
            seg <= seg_next;
            an  <= an_next;
        end
    end

endmodule

// File: doc/bcd_display_scan.md
# bcd_display_scan

Sequential multiplexed seven-segment driver sitting directly downstream of `btd`. It captures the packed BCD word on a load strobe into a shadow register and applies it only at a scan-frame boundary, so no frame ever mixes old and new digits. It then time-multiplexes the digits onto a shared active-low segment bus with per-digit anode enables, with optional leading-zero blanking and a dash for non-decimal nibbles.

## Interface
- `DIGITS`, default 4: number of BCD digits and anodes. `4*DIGITS` equals `Pkg_Global::LENGTH`.
- `REFRESH_DIV`, default 50000: clock cycles each digit stays lit. Must be ≥2.
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-low.
- `bcd_in` input, 4*DIGITS bits: packed BCD. Nibble k is `bcd_in[4k+3:4k]`; digit 0 is least significant.
- `load` input, 1 bit: capture strobe for `bcd_in`; single-cycle or held.
- `blank_lz` input, 1 bit: 1 enables leading-zero blanking. Sampled every cycle.
- `seg` output, 7 bits: segments `{g,f,e,d,c,b,a}`, active-low, registered.
- `an` output, DIGITS bits: anode enables, active-low, one-hot-low or all-high, registered.
- `frame_start` output, 1 bit: one-cycle pulse when the active register is updated at a frame boundary.

## Operation
- Registers:
  - `shadow` (4*DIGITS bits)
  - `active` (4*DIGITS bits)
  - `pending` (1 bit)
  - refresh counter `cnt` (0..REFRESH_DIV-1)
  - digit index `idx` (0..DIGITS-1)
- Reset (asynchronous, `rst`=0):
  - `shadow`, `active`, `cnt`, `idx`, `pending` = 0.
  - `seg` = 7'h7F, `an` = all ones, `frame_start` = 0.
- Load: when `load`=1, `shadow <= bcd_in` and `pending <= 1`. A repeated load before the boundary overwrites `shadow`; the last one wins.
- Tick: `tick = (cnt == REFRESH_DIV-1)`.
  - On tick: `cnt <= 0` and `idx <= (idx==DIGITS-1) ? 0 : idx+1`.
  - Otherwise: `cnt <= cnt+1`.
- Wrap: `wrap = tick & (idx==DIGITS-1)`.
  - On wrap with `pending|load`: `active <= load ? bcd_in : shadow`, `pending <= 0`, `frame_start <= 1`.
  - Otherwise `frame_start <= 0`.
  - A load in the wrap cycle is applied to that same boundary, and `pending` ends at 0.
- Digit decode, from current `idx` and `active`; the result is registered into `seg`/`an` every cycle:
  - Nibble 0..9 uses active-low `gfedcba`: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Nibble 10..15 shows a dash: `seg` = 7'h3F.
  - Blanked when `blank_lz`=1, `idx`≠0, and every nibble from DIGITS-1 down to `idx` is 0. Blanked output is `seg` = 7'h7F and `an` = all ones.
  - Digit 0 is never blanked.
  - Not blanked: `an` = all ones except bit `idx` = 0.
- No arithmetic on BCD contents. Counters wrap only as stated.

## Timing
- `seg`/`an` lag `idx`/`active` by exactly 1 cycle (registered decode).
- First clock edge after `rst` release:
  - `an[0]`=0, `seg`=7'h40 (active=0 shows "0").
  - `idx` advances after REFRESH_DIV cycles.
- Each digit is lit for exactly REFRESH_DIV cycles. The frame is DIGITS*REFRESH_DIV cycles.
- Load to display latency:
  - `active` updates at the next wrap, at most DIGITS*REFRESH_DIV cycles after load.
  - Displayed 1 cycle after that, on digit 0.
- `frame_start` is high in the cycle where the new `active` is first visible to the decode.
- `rst` asserted mid-frame: all state clears immediately, including a pending load, which is discarded.
- `blank_lz` toggling mid-digit takes effect on the next cycle's outputs. No frame sync.

## Test plan
All scenarios use DIGITS=4, REFRESH_DIV=4, so a frame is 16 cycles.
- Reset: hold `rst`=0 for 3 cycles → `seg`=7F, `an`=F, `frame_start`=0. First edge after release → `an`=E, `seg`=40.
- Load and scan: pulse `load` with `bcd_in`=16'h1234 mid-frame → no change until wrap, then `frame_start` pulses once. The next frame shows:
  - `an`=E, `seg`=19 (4), cycles 1-4
  - `an`=D, `seg`=30 (3), cycles 5-8
  - `an`=B, `seg`=24 (2), cycles 9-12
  - `an`=7, `seg`=79 (1), cycles 13-16
- Blanking: `blank_lz`=1 with 16'h0007 → only digit 0 lit (`an`=E, `seg`=78); `an`=F for digits 1-3. With 16'h0000, digit 0 shows 40.
- Invalid nibble: 16'h00A5 with `blank_lz`=0 → digit 0 `seg`=12, digit 1 `seg`=3F, digits 2 and 3 `seg`=40.
- Simultaneous events: load 16'h1111, then load 16'h2222 in the wrap cycle → the next frame shows all 2s, `pending`=0 afterward, and only one `frame_start` pulse.
- Reset mid-operation: load 16'h9999, assert `rst` before the wrap → after release the display shows "0" at digit 0, and 9999 never appears.
